// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl
// Operand-issue and writeback controller for the external 8-bit add/subtract ALU.
// Accepts instructions over a valid/ready handshake, reads two operands from a
// 4-entry register file, issues them to the ALU, captures the result and writes
// it back. LDI bypasses the ALU and writes an immediate. NOP is consumed in place.
//
// Instruction word: [7:6] op (00 ADD, 01 SUB, 10 LDI, 11 NOP), [5:4] rd, [3:2] rs,
// [3:0] LDI immediate.
//
// Ports:
//   clk, rst              clock (rising edge), synchronous active-high reset
//   in_valid/in_instr     instruction from fetch
//   in_ready              high whenever the controller is idle
//   alu_rd_data           ALU operand A (destination register value)
//   alu_rs_data           ALU operand B (source register value)
//   alu_select            0 = add, 1 = subtract (rd - rs)
//   alu_out               combinational ALU result
//   res_valid             one-cycle writeback pulse
//   res_reg/res_data      register and value being written back
//   flag_z/flag_c         zero / carry-borrow flags (only with ALU_FLAGS_EN)
//
// Optional feature macro: ALU_FLAGS_EN adds the flag_z/flag_c ports and logic.

module alu_issue_ctrl #(
  parameter int NREGS = 4,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic [7:0]   in_instr,
  output logic         in_ready,
  output logic [W-1:0] alu_rd_data,
  output logic [W-1:0] alu_rs_data,
  output logic         alu_select,
  input  logic [W-1:0] alu_out,
  output logic         res_valid,
  output logic [1:0]   res_reg,
`ifdef ALU_FLAGS_EN
  output logic [W-1:0] res_data,
  output logic         flag_z,
  output logic         flag_c
`else
  output logic [W-1:0] res_data
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    WB   = 2'd2
  } state_t;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_LDI = 2'b10;

  state_t       state_q, state_d;
  logic [W-1:0] regs_q [NREGS];
  logic [W-1:0] regs_d [NREGS];
  logic [W-1:0] alu_rd_q, alu_rd_d;
  logic [W-1:0] alu_rs_q, alu_rs_d;
  logic         alu_sel_q, alu_sel_d;
  logic         res_valid_q, res_valid_d;
  logic [1:0]   res_reg_q, res_reg_d;
  logic [W-1:0] res_data_q, res_data_d;

`ifdef ALU_FLAGS_EN
  // Carry/borrow is evaluated while the operands are on the ALU and held until
  // WB commits it, so the flag tracks exactly the result being written back.
  logic         is_alu_q, is_alu_d;
  logic         carry_pend_q, carry_pend_d;
  logic         flag_z_q, flag_z_d;
  logic         flag_c_q, flag_c_d;
`endif

  logic [1:0]   dec_op;
  logic [1:0]   dec_rd;
  logic [1:0]   dec_rs;
  logic [W-1:0] dec_imm;

  assign dec_op  = in_instr[7:6];
  assign dec_rd  = in_instr[5:4];
  assign dec_rs  = in_instr[3:2];
  assign dec_imm = W'(in_instr[3:0]);

  // Next-state and datapath logic; operands are read only in IDLE, so any
  // preceding writeback has already landed in the register file.
  always_comb begin
    state_d     = state_q;
    regs_d      = regs_q;
    alu_rd_d    = alu_rd_q;
    alu_rs_d    = alu_rs_q;
    alu_sel_d   = alu_sel_q;
    res_valid_d = 1'b0;
    res_reg_d   = res_reg_q;
    res_data_d  = res_data_q;
`ifdef ALU_FLAGS_EN
    is_alu_d     = is_alu_q;
    carry_pend_d = carry_pend_q;
    flag_z_d     = flag_z_q;
    flag_c_d     = flag_c_q;
`endif

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          if (dec_op == OP_ADD || dec_op == OP_SUB) begin
            alu_rd_d  = regs_q[dec_rd];
            alu_rs_d  = regs_q[dec_rs];
            alu_sel_d = dec_op[0];
            res_reg_d = dec_rd;
            state_d   = EXEC;
`ifdef ALU_FLAGS_EN
            is_alu_d  = 1'b1;
`endif
          end else if (dec_op == OP_LDI) begin
            res_data_d  = dec_imm;
            res_reg_d   = dec_rd;
            res_valid_d = 1'b1;
            state_d     = WB;
`ifdef ALU_FLAGS_EN
            is_alu_d    = 1'b0;
`endif
          end
        end
      end

      EXEC: begin
        res_data_d  = alu_out;
        res_valid_d = 1'b1;
        state_d     = WB;
`ifdef ALU_FLAGS_EN
        carry_pend_d = alu_sel_q ? (alu_rd_q < alu_rs_q) : (alu_out < alu_rd_q);
`endif
      end

      WB: begin
        regs_d[res_reg_q] = res_data_q;
        state_d           = IDLE;
`ifdef ALU_FLAGS_EN
        if (is_alu_q) begin
          flag_z_d = (res_data_q == '0);
          flag_c_d = carry_pend_q;
        end
`endif
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Single state register; reset in EXEC or WB drops the pending writeback.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
      alu_rd_q    <= '0;
      alu_rs_q    <= '0;
      alu_sel_q   <= 1'b0;
      res_valid_q <= 1'b0;
      res_reg_q   <= '0;
      res_data_q  <= '0;
`ifdef ALU_FLAGS_EN
      is_alu_q     <= 1'b0;
      carry_pend_q <= 1'b0;
      flag_z_q     <= 1'b0;
      flag_c_q     <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      regs_q      <= regs_d;
      alu_rd_q    <= alu_rd_d;
      alu_rs_q    <= alu_rs_d;
      alu_sel_q   <= alu_sel_d;
      res_valid_q <= res_valid_d;
      res_reg_q   <= res_reg_d;
      res_data_q  <= res_data_d;
`ifdef ALU_FLAGS_EN
      is_alu_q     <= is_alu_d;
      carry_pend_q <= carry_pend_d;
      flag_z_q     <= flag_z_d;
      flag_c_q     <= flag_c_d;
`endif
    end
  end

  assign in_ready    = (state_q == IDLE);
  assign alu_rd_data = alu_rd_q;
  assign alu_rs_data = alu_rs_q;
  assign alu_select  = alu_sel_q;
  assign res_valid   = res_valid_q;
  assign res_reg     = res_reg_q;
  assign res_data    = res_data_q;
`ifdef ALU_FLAGS_EN
  assign flag_z      = flag_z_q;
  assign flag_c      = flag_c_q;
`endif

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Testbench for alu_issue_ctrl.
// Stands in for the ALU with a combinational add/subtract, drives directed
// instruction sequences, and checks the controller every cycle against a
// transaction-level model (register array plus cycle countdowns), together
// with literal expected results for each directed instruction.

module tb_alu_issue_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [7:0] in_instr;
  logic       in_ready;
  logic [7:0] alu_rd_data;
  logic [7:0] alu_rs_data;
  logic       alu_select;
  logic [7:0] alu_out;
  logic       res_valid;
  logic [1:0] res_reg;
  logic [7:0] res_data;
`ifdef ALU_FLAGS_EN
  logic       flag_z;
  logic       flag_c;
`endif

  int checks   = 0;
  int failures = 0;
  bit armed    = 1'b0;

  alu_issue_ctrl #(.NREGS(4), .W(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_instr    (in_instr),
    .in_ready    (in_ready),
    .alu_rd_data (alu_rd_data),
    .alu_rs_data (alu_rs_data),
    .alu_select  (alu_select),
    .alu_out     (alu_out),
    .res_valid   (res_valid),
    .res_reg     (res_reg),
`ifdef ALU_FLAGS_EN
    .res_data    (res_data),
    .flag_z      (flag_z),
    .flag_c      (flag_c)
`else
    .res_data    (res_data)
`endif
  );

  // Stand-in for the external ALU.
  assign alu_out = alu_select ? (alu_rd_data - alu_rs_data) : (alu_rd_data + alu_rs_data);

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Model state: expected outputs for the current cycle plus countdowns.
  int mRegs [4];
  bit mReady, mResValid, mSel, mIsAlu, mCarry, mFlagZ, mFlagC;
  int mResReg, mResData, mAluRd, mAluRs;
  int busy, wbCount;

  task automatic modelReset();
    for (int i = 0; i < 4; i++) mRegs[i] = 0;
    mReady = 1; mResValid = 0; mSel = 0; mIsAlu = 0; mCarry = 0;
    mFlagZ = 0; mFlagC = 0; mResReg = 0; mResData = 0; mAluRd = 0; mAluRs = 0;
    busy = 0; wbCount = 0;
  endtask

  // Compare this cycle, then advance the model to the next cycle.
  always @(negedge clk) begin
    bit nextValid;
    int op, rd, rs;
    if (armed) begin
      checkOutput("in_ready", in_ready, mReady);
      checkOutput("res_valid", res_valid, mResValid);
      checkOutput("alu_rd_data", alu_rd_data, mAluRd);
      checkOutput("alu_rs_data", alu_rs_data, mAluRs);
      checkOutput("alu_select", alu_select, mSel);
      if (mResValid) begin
        checkOutput("res_reg", res_reg, mResReg);
        checkOutput("res_data", res_data, mResData);
      end
`ifdef ALU_FLAGS_EN
      checkOutput("flag_z", flag_z, mFlagZ);
      checkOutput("flag_c", flag_c, mFlagC);
`endif
    end
    if (rst) begin
      modelReset();
    end else begin
      if (mResValid) begin
        mRegs[mResReg] = mResData;
        if (mIsAlu) begin
          mFlagZ = (mResData == 0);
          mFlagC = mCarry;
        end
      end
      nextValid = 0;
      if (wbCount > 0) begin
        wbCount--;
        if (wbCount == 0) nextValid = 1;
      end
      if (busy > 0) busy--;
      if (mReady && in_valid) begin
        op = in_instr[7:6];
        rd = in_instr[5:4];
        rs = in_instr[3:2];
        if (op == 0 || op == 1) begin
          mAluRd  = mRegs[rd];
          mAluRs  = mRegs[rs];
          mSel    = (op == 1);
          mResReg = rd;
          mIsAlu  = 1;
          if (op == 0) begin
            mResData = (mRegs[rd] + mRegs[rs]) % 256;
            mCarry   = (mRegs[rd] + mRegs[rs]) > 255;
          end else begin
            mResData = (mRegs[rd] - mRegs[rs] + 256) % 256;
            mCarry   = mRegs[rd] < mRegs[rs];
          end
          wbCount = 1;
          busy    = 2;
        end else if (op == 2) begin
          mResReg   = rd;
          mResData  = in_instr[3:0];
          mIsAlu    = 0;
          nextValid = 1;
          busy      = 1;
        end
      end
      mReady    = (busy == 0);
      mResValid = nextValid;
    end
  end

  // Present one instruction and hold it until a cycle with in_ready high.
  task automatic applyStimulus(input logic [7:0] instr);
    bit accepted;
    in_instr = instr;
    in_valid = 1'b1;
    for (int g = 0; g < 10; g++) begin
      @(negedge clk);
      accepted = in_ready;
      @(posedge clk);
      #1;
      if (accepted) break;
      if (g == 9) checkOutput("accept_timeout", 32'd0, 32'd1);
    end
    in_valid = 1'b0;
  endtask

  // Wait (bounded) for the writeback pulse and return what it carried.
  task automatic waitResult(output logic [7:0] data, output logic [1:0] rg);
    bit seen = 0;
    data = 8'hxx;
    rg   = 2'bxx;
    for (int g = 0; g < 6 && !seen; g++) begin
      @(negedge clk);
      if (res_valid === 1'b1) begin
        data = res_data;
        rg   = res_reg;
        seen = 1;
      end
    end
    if (!seen) checkOutput("res_valid_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic runOp(input string name, input logic [7:0] instr, input logic [1:0] expReg, input logic [7:0] expData);
    logic [7:0] d;
    logic [1:0] r;
    applyStimulus(instr);
    waitResult(d, r);
    checkOutput({name, "_data"}, d, expData);
    checkOutput({name, "_reg"}, r, expReg);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired actual=running required=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [7:0] d;
    logic [1:0] r;
    rst      = 1'b1;
    in_valid = 1'b0;
    in_instr = 8'h00;
    modelReset();
    repeat (2) @(posedge clk);
    #1;
    armed = 1'b1;
    rst   = 1'b0;

    // Reset state.
    checkOutput("rst_in_ready", in_ready, 1);
    checkOutput("rst_res_valid", res_valid, 0);
    checkOutput("rst_alu_rd", alu_rd_data, 0);
    checkOutput("rst_res_data", res_data, 0);

    // LDI r1,5 / LDI r2,3 / SUB r1,r2 with operands visible in EXEC.
    runOp("ldi_r1_5", 8'h95, 2'd1, 8'h05);
    runOp("ldi_r2_3", 8'hA3, 2'd2, 8'h03);
    applyStimulus(8'h58);
    checkOutput("sub_exec_ready", in_ready, 0);
    checkOutput("sub_exec_select", alu_select, 1);
    checkOutput("sub_exec_rd", alu_rd_data, 8'h05);
    checkOutput("sub_exec_rs", alu_rs_data, 8'h03);
    waitResult(d, r);
    checkOutput("sub_r1_r2_data", d, 8'h02);

    // Doubling chain with wrap.
    runOp("ldi_r0_15", 8'h8F, 2'd0, 8'h0F);
    runOp("add_r0_1", 8'h00, 2'd0, 8'h1E);
    runOp("add_r0_2", 8'h00, 2'd0, 8'h3C);
    runOp("add_r0_3", 8'h00, 2'd0, 8'h78);
    runOp("add_r0_4", 8'h00, 2'd0, 8'hF0);
`ifdef ALU_FLAGS_EN
    checkOutput("flag_c_no_wrap", flag_c, 0);
`endif
    runOp("add_r0_5", 8'h00, 2'd0, 8'hE0);
`ifdef ALU_FLAGS_EN
    checkOutput("flag_c_wrap", flag_c, 1);
`endif

    // Self-subtract to zero, then borrow.
    runOp("sub_r3_r3", 8'h7C, 2'd3, 8'h00);
`ifdef ALU_FLAGS_EN
    checkOutput("flag_z_zero", flag_z, 1);
    checkOutput("flag_c_zero", flag_c, 0);
`endif
    runOp("ldi_r1_5b", 8'h95, 2'd1, 8'h05);
    runOp("sub_r3_r1", 8'h74, 2'd3, 8'hFB);
`ifdef ALU_FLAGS_EN
    checkOutput("flag_c_borrow", flag_c, 1);
    checkOutput("flag_z_borrow", flag_z, 0);
`endif

    // NOP stream with in_valid held high.
    in_instr = 8'hC0;
    in_valid = 1'b1;
    repeat (6) begin
      @(posedge clk);
      #1;
      checkOutput("nop_ready", in_ready, 1);
    end
    in_valid = 1'b0;
    runOp("add_r2_r1", 8'h24, 2'd2, 8'h08);

    // Reset during EXEC aborts the writeback.
    applyStimulus(8'h14);
    rst = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("abort_res_valid", res_valid, 0);
    checkOutput("abort_alu_rd", alu_rd_data, 0);
    checkOutput("abort_res_data", res_data, 0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("abort_in_ready", in_ready, 1);
    runOp("add_r1_r2_after_rst", 8'h18, 2'd1, 8'h00);

    repeat (3) @(posedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
